// File: rtl/clock_disp_pkg.sv
// Shared constants and the binary-to-BCD helper for the HH:MM scanning display.
package clock_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [1:0] DIG_MIN_ONES = 2'd0;
  localparam logic [1:0] DIG_MIN_TENS = 2'd1;
  localparam logic [1:0] DIG_HR_ONES  = 2'd2;
  localparam logic [1:0] DIG_HR_TENS  = 2'd3;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Repeated compare-and-subtract; six steps cover any 6-bit value (max 63).
  function automatic bcd2_t split_bcd(input logic [5:0] v);
    bcd2_t      r;
    logic [5:0] rem;
    r.tens = 4'd0;
    rem    = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem    = rem - 6'd10;
        r.tens = r.tens + 4'd1;
      end
    end
    r.ones = 4'(rem);
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Maps a digit code (0-9, E=dash, F=blank) to an active-low gfedcba pattern.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit HH:MM driver; time is snapshotted once per scan frame so
// a rollover in the counters never shows up as a torn reading.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZB         = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic       sec_pulse,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       shadow_h_q, shadow_h_d;
  logic [5:0]       shadow_m_q, shadow_m_d;
  logic             colon_q, colon_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  bcd2_t      hr_bcd, mn_bcd;
  logic       hr_ok, mn_ok;
  logic [3:0] digit_code;
  logic [6:0] seg_enc;

  always_comb begin
    tick       = (cnt_q == CNT_LAST);
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    shadow_h_d = shadow_h_q;
    shadow_m_d = shadow_m_q;
    // Load only at the end of the hours-tens slot, i.e. on the frame boundary.
    if (tick && idx_q == DIG_HR_TENS) begin
      shadow_h_d = hours;
      shadow_m_d = minutes;
    end
    colon_d = colon_q ^ sec_pulse;
  end

  always_comb begin
    hr_bcd     = split_bcd({1'b0, shadow_h_q});
    mn_bcd     = split_bcd(shadow_m_q);
    hr_ok      = (shadow_h_q <= HR_MAX);
    mn_ok      = (shadow_m_q <= MIN_MAX);
    digit_code = CODE_DASH;
    case (idx_q)
      DIG_MIN_ONES: digit_code = mn_ok ? mn_bcd.ones : CODE_DASH;
      DIG_MIN_TENS: digit_code = mn_ok ? mn_bcd.tens : CODE_DASH;
      DIG_HR_ONES:  digit_code = hr_ok ? hr_bcd.ones : CODE_DASH;
      default: begin
        if (!hr_ok)
          digit_code = CODE_DASH;
        else if (LZB && hr_bcd.tens == 4'd0)
          digit_code = CODE_BLANK;
        else
          digit_code = hr_bcd.tens;
      end
    endcase
  end

  seg7_encode u_seg7 (
    .code (digit_code),
    .seg  (seg_enc)
  );

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_enc;
    dp_d  = ~((idx_q == DIG_HR_ONES) && colon_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      shadow_h_q <= 5'd0;
      shadow_m_q <= 6'd0;
      colon_q    <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_h_q <= shadow_h_d;
      shadow_m_q <= shadow_m_d;
      colon_q    <= colon_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench: a time-indexed model predicts each cycle's display for an
// LZB=0 and an LZB=1 instance; a negedge monitor pops and compares.
module tb_clock_display_scan;

  localparam int DIV = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       sec_pulse;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Digits 0-9, then dash (10) and blank (11).
  logic [6:0] seg_tab [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};

  int unsigned m_t     = 0;
  int          m_sh    = 0;
  int          m_sm    = 0;
  bit          m_colon = 1'b0;

  always #5 clk = ~clk;

  clock_display_scan #(.REFRESH_DIV(DIV), .LZB(1'b0)) u_dut (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes),
    .sec_pulse(sec_pulse), .an(an0), .seg(seg0), .dp(dp0)
  );

  clock_display_scan #(.REFRESH_DIV(DIV), .LZB(1'b1)) u_dut_lzb (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes),
    .sec_pulse(sec_pulse), .an(an1), .seg(seg1), .dp(dp1)
  );

  function automatic int cur_idx(int unsigned t);
    return int'((t / DIV) % 4);
  endfunction

  function automatic exp_t expect_out(int idx, int sh, int sm, bit lzb, bit colon);
    exp_t e;
    int   d;
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    e.an   = ~onehot;
    e.dp   = !(idx == 2 && colon);
    if (idx < 2) begin
      if (sm > 59)       d = 10;
      else if (idx == 0) d = sm % 10;
      else               d = sm / 10;
    end else begin
      if (sh > 23)                     d = 10;
      else if (idx == 2)               d = sh % 10;
      else if (lzb && (sh / 10) == 0)  d = 11;
      else                             d = sh / 10;
    end
    e.seg = seg_tab[d];
    return e;
  endfunction

  // Reference model: the display is a pure function of time since reset.
  always @(posedge clk) begin
    if (rst) begin
      q0.push_back('{4'hF, 7'h7F, 1'b1});
      q1.push_back('{4'hF, 7'h7F, 1'b1});
      m_t     <= 0;
      m_sh    <= 0;
      m_sm    <= 0;
      m_colon <= 1'b0;
    end else begin
      q0.push_back(expect_out(cur_idx(m_t), m_sh, m_sm, 1'b0, m_colon));
      q1.push_back(expect_out(cur_idx(m_t), m_sh, m_sm, 1'b1, m_colon));
      if ((m_t % DIV) == DIV - 1 && cur_idx(m_t) == 3) begin
        m_sh <= int'(hours);
        m_sm <= int'(minutes);
      end
      if (sec_pulse) m_colon <= !m_colon;
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input exp_t e);
    n_checks++;
    if (a !== e.an || s !== e.seg || d !== e.dp) begin
      n_errors++;
      $display("FAIL %s @%0t: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, $time, a, s, d, e.an, e.seg, e.dp);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check("lzb0", an0, seg0, dp0, q0.pop_front());
    if (q1.size() > 0) check("lzb1", an1, seg1, dp1, q1.pop_front());
  end

  task automatic step(input logic r, input logic sp);
    rst       = r;
    sec_pulse = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    hours     = 5'd13;
    minutes   = 6'd47;
    sec_pulse = 1'b0;

    $display("txn reset: rst held 3 cycles");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    $display("txn frame load: 13:47");
    run(32);

    $display("txn colon: two sec pulses");
    step(1'b0, 1'b1);
    run(16);
    step(1'b0, 1'b1);
    run(16);

    $display("txn anti-tear: 23:59 then 00:00 mid-frame");
    hours   = 5'd23;
    minutes = 6'd59;
    run(20);
    while (cur_idx(m_t) != 1) run(1);
    hours   = 5'd0;
    minutes = 6'd0;
    run(24);

    $display("txn out of range: 25:07");
    hours   = 5'd25;
    minutes = 6'd7;
    run(32);

    $display("txn leading zero: 05:30 then mid-frame reset");
    hours   = 5'd5;
    minutes = 6'd30;
    run(30);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(8);

    $display("txn random: 2500 cycles");
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        hours   = 5'($urandom_range(0, 31));
        minutes = 6'($urandom_range(0, 63));
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
    end

    run(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
